// File: rtl/core_outport_uart_tx.sv
`default_nettype none
// ============================================================================
//  Module   : core_outport_uart_tx
//  Purpose  : Outport UART transmitter for the 9x8 core. Bytes written by the
//             core are buffered in a small FIFO and sent as 8N1 frames.
//             Busy / full / sticky-overflow status is exposed for readback.
//  Options  : define CORE_OUTPORT_UART_TX_PARITY_EN to insert an even-parity
//             bit after the data bits (8E1).
//  Revision : 1.0  initial release
// ============================================================================
module core_outport_uart_tx #(
    parameter int G_CLK_PER_BAUD = 100,   // clock cycles per UART bit (2..65535)
    parameter int G_FIFO_DEPTH   = 16,    // FIFO entries, power of 2 (2..256)
    parameter int G_NSTOP        = 1      // stop bits per frame (1 or 2)
) (
    input  logic       i_clk,
    input  logic       i_rst,             // synchronous, active-low
    input  logic       i_wr,
    input  logic [7:0] i_data,
    input  logic       i_ovf_clr,
    output logic       o_uart_tx,
    output logic       o_busy,
    output logic       o_full,
    output logic       o_overflow
);

    localparam int              c_AW          = $clog2(G_FIFO_DEPTH);
    localparam int              c_CW          = $clog2(G_FIFO_DEPTH) + 1;
    localparam logic [c_CW-1:0] c_DEPTH       = c_CW'(G_FIFO_DEPTH);
    localparam logic [15:0]     c_BAUD_RELOAD = 16'(G_CLK_PER_BAUD - 1);
    localparam logic            c_LAST_STOP   = 1'(G_NSTOP - 1);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_START  = 3'd1,
        S_DATA   = 3'd2,
        S_STOP   = 3'd4
`ifdef CORE_OUTPORT_UART_TX_PARITY_EN
        ,S_PARITY = 3'd3
`endif
    } state_t;

    // FIFO storage and bookkeeping
    logic [7:0]      r_mem [G_FIFO_DEPTH];
    logic [c_AW-1:0] r_wr_ptr;
    logic [c_AW-1:0] r_rd_ptr;
    logic [c_CW-1:0] r_count;
    logic [c_CW-1:0] w_count_nxt;
    logic            r_full;
    logic            r_overflow;

    // Serialiser state
    state_t          r_state;
    logic [15:0]     r_baud;
    logic [2:0]      r_bit_idx;
    logic            r_stop_idx;
    logic [7:0]      r_shift;
    logic            r_tx;
    logic            r_busy;
`ifdef CORE_OUTPORT_UART_TX_PARITY_EN
    logic            r_parity;
`endif

    logic            w_wr_acc;
    logic            w_fifo_nempty;
    logic            w_bit_end;
    logic            w_stop_done;
    logic            w_pop;
    logic            w_active_nxt;

    // A write is taken only when the FIFO was not full at the start of the cycle,
    // regardless of a pop happening in the same cycle.
    assign w_wr_acc      = i_wr && !r_full;
    assign w_fifo_nempty = (r_count != '0);
    assign w_bit_end     = (r_baud == 16'd0);
    assign w_stop_done   = (r_state == S_STOP) && w_bit_end && (r_stop_idx == c_LAST_STOP);
    // Pop from idle, or straight out of the last stop bit to chain frames gaplessly
    assign w_pop         = w_fifo_nempty && ((r_state == S_IDLE) || w_stop_done);
    // FSM will be outside IDLE next cycle
    assign w_active_nxt  = w_pop || ((r_state != S_IDLE) && !w_stop_done);

    // Next FIFO occupancy from accepted write and pop
    always_comb begin
        w_count_nxt = r_count;
        if (w_wr_acc && !w_pop) begin
            w_count_nxt = r_count + 1'b1;
        end else if (!w_wr_acc && w_pop) begin
            w_count_nxt = r_count - 1'b1;
        end
    end

    // FIFO data array; contents need no reset since the count gates reads
    always_ff @(posedge i_clk) begin
        if (w_wr_acc) begin
            r_mem[r_wr_ptr] <= i_data;
        end
    end

    // FIFO pointers, occupancy, full flag and sticky overflow
    always_ff @(posedge i_clk) begin
        if (!i_rst) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_count    <= '0;
            r_full     <= 1'b0;
            r_overflow <= 1'b0;
        end else begin
            if (w_wr_acc) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            r_count <= w_count_nxt;
            r_full  <= (w_count_nxt == c_DEPTH);
            // A drop in the same cycle as a clear keeps the flag set
            if (i_wr && r_full) begin
                r_overflow <= 1'b1;
            end else if (i_ovf_clr) begin
                r_overflow <= 1'b0;
            end
        end
    end

    // Frame sequencer: start, 8 data bits LSB first, optional parity, stop bit(s)
    always_ff @(posedge i_clk) begin
        if (!i_rst) begin
            r_state    <= S_IDLE;
            r_baud     <= 16'd0;
            r_bit_idx  <= 3'd0;
            r_stop_idx <= 1'b0;
            r_shift    <= 8'd0;
            r_tx       <= 1'b1;
            r_busy     <= 1'b0;
`ifdef CORE_OUTPORT_UART_TX_PARITY_EN
            r_parity   <= 1'b0;
`endif
        end else begin
            r_busy <= (w_count_nxt != '0) || w_active_nxt;
            case (r_state)
                S_IDLE: begin
                    if (w_pop) begin
                        r_shift <= r_mem[r_rd_ptr];
`ifdef CORE_OUTPORT_UART_TX_PARITY_EN
                        r_parity <= ^r_mem[r_rd_ptr];
`endif
                        r_baud  <= c_BAUD_RELOAD;
                        r_tx    <= 1'b0;
                        r_state <= S_START;
                    end
                end
                S_START: begin
                    if (w_bit_end) begin
                        r_baud    <= c_BAUD_RELOAD;
                        r_bit_idx <= 3'd0;
                        r_tx      <= r_shift[0];
                        r_shift   <= {1'b0, r_shift[7:1]};
                        r_state   <= S_DATA;
                    end else begin
                        r_baud <= r_baud - 16'd1;
                    end
                end
                S_DATA: begin
                    if (w_bit_end) begin
                        r_baud <= c_BAUD_RELOAD;
                        if (r_bit_idx == 3'd7) begin
`ifdef CORE_OUTPORT_UART_TX_PARITY_EN
                            r_tx    <= r_parity;
                            r_state <= S_PARITY;
`else
                            r_tx       <= 1'b1;
                            r_stop_idx <= 1'b0;
                            r_state    <= S_STOP;
`endif
                        end else begin
                            r_bit_idx <= r_bit_idx + 3'd1;
                            r_tx      <= r_shift[0];
                            r_shift   <= {1'b0, r_shift[7:1]};
                        end
                    end else begin
                        r_baud <= r_baud - 16'd1;
                    end
                end
`ifdef CORE_OUTPORT_UART_TX_PARITY_EN
                S_PARITY: begin
                    if (w_bit_end) begin
                        r_baud     <= c_BAUD_RELOAD;
                        r_tx       <= 1'b1;
                        r_stop_idx <= 1'b0;
                        r_state    <= S_STOP;
                    end else begin
                        r_baud <= r_baud - 16'd1;
                    end
                end
`endif
                S_STOP: begin
                    if (w_bit_end) begin
                        r_baud <= c_BAUD_RELOAD;
                        if (w_stop_done) begin
                            if (w_pop) begin
                                r_shift <= r_mem[r_rd_ptr];
`ifdef CORE_OUTPORT_UART_TX_PARITY_EN
                                r_parity <= ^r_mem[r_rd_ptr];
`endif
                                r_tx    <= 1'b0;
                                r_state <= S_START;
                            end else begin
                                r_tx    <= 1'b1;
                                r_state <= S_IDLE;
                            end
                        end else begin
                            r_stop_idx <= 1'b1;
                        end
                    end else begin
                        r_baud <= r_baud - 16'd1;
                    end
                end
                default: begin
                    r_tx    <= 1'b1;
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign o_uart_tx  = r_tx;
    assign o_busy     = r_busy;
    assign o_full     = r_full;
    assign o_overflow = r_overflow;

endmodule
`default_nettype wire

// File: tb/tb_core_outport_uart_tx.sv
`default_nettype none
// ============================================================================
//  Module   : tb_core_outport_uart_tx
//  Purpose  : Self-checking bench for core_outport_uart_tx. A bit-level
//             receiver decodes frames and compares them against a queue of
//             expected bytes pushed when writes are driven.
//  Revision : 1.0  initial release
// ============================================================================
module tb_core_outport_uart_tx;

    localparam int BAUD = 4;
`ifdef CORE_OUTPORT_UART_TX_PARITY_EN
    localparam int FRAME_BITS = 11;
`else
    localparam int FRAME_BITS = 10;
`endif
    localparam int FRAME_CYC = FRAME_BITS * BAUD;

    logic       clk;
    logic       rst;
    logic       wr;
    logic [7:0] data;
    logic       ovf_clr;
    logic       uart_tx;
    logic       busy;
    logic       full;
    logic       overflow;

    int         cyc;
    int         checks;
    int         errors;
    logic       rx_en;
    logic [7:0] exp_q[$];
    int         start_q[$];

    core_outport_uart_tx #(
        .G_CLK_PER_BAUD (BAUD),
        .G_FIFO_DEPTH   (4),
        .G_NSTOP        (1)
    ) dut (
        .i_clk      (clk),
        .i_rst      (rst),
        .i_wr       (wr),
        .i_data     (data),
        .i_ovf_clr  (ovf_clr),
        .o_uart_tx  (uart_tx),
        .o_busy     (busy),
        .o_full     (full),
        .o_overflow (overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial cyc = 0;
    always @(posedge clk) cyc++;

    // Expected line level for bit k of a frame carrying d
    function automatic logic frame_bit(input logic [7:0] d, input int k);
        if (k == 0) return 1'b0;
        if (k <= 8) return d[k-1];
`ifdef CORE_OUTPORT_UART_TX_PARITY_EN
        if (k == 9) return ^d;
`endif
        return 1'b1;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Receiver: detects start bits, samples mid-bit, checks against scoreboard
    initial begin : rx
        logic       prev;
        logic [7:0] b;
        logic [7:0] e;
        prev = 1'b1;
        b    = 8'd0;
        forever begin
            @(negedge clk);
            if (rx_en && prev === 1'b1 && uart_tx === 1'b0) begin
                start_q.push_back(cyc);
                repeat (2) @(negedge clk);
                checks++;
                if (uart_tx !== 1'b0) begin
                    errors++;
                    $display("FAIL rx_start_bit: got %b want 0 at cycle %0d", uart_tx, cyc);
                end
                for (int i = 0; i < 8; i++) begin
                    repeat (BAUD) @(negedge clk);
                    b[i] = uart_tx;
                end
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL rx_unexpected_frame: got %02h want none", b);
                    e = 8'hxx;
                end else begin
                    e = exp_q.pop_front();
                    if (b !== e) begin
                        errors++;
                        $display("FAIL rx_data: got %02h want %02h", b, e);
                    end
                end
`ifdef CORE_OUTPORT_UART_TX_PARITY_EN
                repeat (BAUD) @(negedge clk);
                checks++;
                if (uart_tx !== ^e) begin
                    errors++;
                    $display("FAIL rx_parity: got %b want %b for %02h", uart_tx, ^e, e);
                end
`endif
                repeat (BAUD) @(negedge clk);
                checks++;
                if (uart_tx !== 1'b1) begin
                    errors++;
                    $display("FAIL rx_stop_bit: got %b want 1", uart_tx);
                end
                prev = 1'b1;
            end else begin
                prev = uart_tx;
            end
        end
    end

    // Wait (bounded) for o_busy to drop, then realign to drive point
    task automatic wait_idle(input int max_cyc);
        int n;
        n = 0;
        @(negedge clk);
        while (busy === 1'b1 && n < max_cyc) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL wait_idle_timeout: busy=%b want 0 after %0d cycles", busy, n);
        end
        tick();
    endtask

    task automatic test_reset();
        rst = 1'b0;
        repeat (5) tick();
        @(negedge clk);
        checks++;
        if ({uart_tx, busy, full, overflow} !== 4'b1000) begin
            errors++;
            $display("FAIL reset_outputs: tx/busy/full/ovf=%b want 1000", {uart_tx, busy, full, overflow});
        end
        tick();
        rst = 1'b1;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            checks++;
            if (uart_tx !== 1'b1 || busy !== 1'b0) begin
                errors++;
                $display("FAIL reset_idle: tx=%b busy=%b want tx=1 busy=0 cycle %0d", uart_tx, busy, i);
            end
        end
        tick();
    endtask

    task automatic test_single();
        int         n;
        int         t;
        logic       etx;
        logic       ebusy;
        logic [7:0] d;
        d = 8'hA5;
        start_q.delete();
        exp_q.push_back(d);
        n    = cyc;
        wr   = 1'b1;
        data = d;
        tick();
        wr   = 1'b0;
        for (int c = n + 1; c <= n + 2 + FRAME_CYC; c++) begin
            @(negedge clk);
            t     = c - n - 2;
            etx   = (t < 0 || t >= FRAME_CYC) ? 1'b1 : frame_bit(d, t / BAUD);
            ebusy = (c < n + 2 + FRAME_CYC);
            checks++;
            if (uart_tx !== etx || busy !== ebusy) begin
                errors++;
                $display("FAIL single_wave: N+%0d tx=%b busy=%b want tx=%b busy=%b", c - n, uart_tx, busy, etx, ebusy);
            end
        end
        checks++;
        if (exp_q.size() != 0 || start_q.size() != 1) begin
            errors++;
            $display("FAIL single_frames: pending=%0d starts=%0d want 0 and 1", exp_q.size(), start_q.size());
        end else if (start_q[0] != n + 2) begin
            errors++;
            $display("FAIL single_start: start at N+%0d want N+2", start_q[0] - n);
        end
        tick();
    endtask

    task automatic test_back_to_back();
        int n;
        start_q.delete();
        exp_q.push_back(8'h00);
        exp_q.push_back(8'hFF);
        n    = cyc;
        wr   = 1'b1;
        data = 8'h00;
        tick();
        data = 8'hFF;
        tick();
        wr   = 1'b0;
        wait_idle(4 * FRAME_CYC);
        checks++;
        if (start_q.size() != 2) begin
            errors++;
            $display("FAIL b2b_frames: got %0d starts want 2", start_q.size());
        end else if (start_q[1] - start_q[0] != FRAME_CYC || start_q[0] != n + 2) begin
            errors++;
            $display("FAIL b2b_gap: first at N+%0d gap %0d want N+2 gap %0d", start_q[0] - n, start_q[1] - start_q[0], FRAME_CYC);
        end
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL b2b_pending: got %0d want 0", exp_q.size());
        end
    endtask

    task automatic test_overflow();
        for (int i = 1; i <= 5; i++) exp_q.push_back(8'(i));
        for (int i = 1; i <= 6; i++) begin
            wr   = 1'b1;
            data = 8'(i);
            tick();
        end
        wr = 1'b0;
        @(negedge clk);
        checks++;
        if (full !== 1'b1 || overflow !== 1'b1) begin
            errors++;
            $display("FAIL ovf_set: full=%b ovf=%b want 1 1", full, overflow);
        end
        tick();
        ovf_clr = 1'b1;
        tick();
        ovf_clr = 1'b0;
        @(negedge clk);
        checks++;
        if (overflow !== 1'b0) begin
            errors++;
            $display("FAIL ovf_clear: ovf=%b want 0", overflow);
        end
        tick();
        // Drop and clear together: the set must win
        wr      = 1'b1;
        data    = 8'h77;
        ovf_clr = 1'b1;
        tick();
        wr      = 1'b0;
        ovf_clr = 1'b0;
        @(negedge clk);
        checks++;
        if (overflow !== 1'b1 || full !== 1'b1) begin
            errors++;
            $display("FAIL ovf_set_wins: ovf=%b full=%b want 1 1", overflow, full);
        end
        tick();
        ovf_clr = 1'b1;
        tick();
        ovf_clr = 1'b0;
        wait_idle(6 * FRAME_CYC);
        checks++;
        if (exp_q.size() != 0 || full !== 1'b0 || overflow !== 1'b0) begin
            errors++;
            $display("FAIL ovf_drain: pending=%0d full=%b ovf=%b want 0 0 0", exp_q.size(), full, overflow);
        end
    endtask

    task automatic test_reset_midframe();
        rx_en = 1'b0;
        wr    = 1'b1;
        data  = 8'h55;
        tick();
        data  = 8'h11;
        tick();
        data  = 8'h22;
        tick();
        wr    = 1'b0;
        // Now in cycle N+3; data bit 3 spans N+18..N+21
        repeat (16) tick();
        @(negedge clk);
        checks++;
        if (uart_tx !== 1'b0 || busy !== 1'b1) begin
            errors++;
            $display("FAIL midframe_bit3: tx=%b busy=%b want 0 1", uart_tx, busy);
        end
        rst = 1'b0;
        tick();
        @(negedge clk);
        checks++;
        if (uart_tx !== 1'b1 || busy !== 1'b0 || full !== 1'b0) begin
            errors++;
            $display("FAIL midframe_reset: tx=%b busy=%b full=%b want 1 0 0", uart_tx, busy, full);
        end
        tick();
        rst = 1'b1;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            checks++;
            if (uart_tx !== 1'b1 || busy !== 1'b0) begin
                errors++;
                $display("FAIL midframe_quiet: tx=%b busy=%b want 1 0 cycle %0d", uart_tx, busy, i);
            end
        end
        tick();
        rx_en = 1'b1;
    endtask

`ifdef CORE_OUTPORT_UART_TX_PARITY_EN
    task automatic test_parity();
        start_q.delete();
        exp_q.push_back(8'h07);
        exp_q.push_back(8'h03);
        wr   = 1'b1;
        data = 8'h07;
        tick();
        data = 8'h03;
        tick();
        wr   = 1'b0;
        wait_idle(4 * FRAME_CYC);
        checks++;
        if (start_q.size() != 2 || start_q[1] - start_q[0] != 44 || exp_q.size() != 0) begin
            errors++;
            $display("FAIL parity_frame: starts=%0d pending=%0d want 2 frames 44 apart", start_q.size(), exp_q.size());
        end
    endtask
`endif

    initial begin : main
        rst     = 1'b0;
        wr      = 1'b0;
        data    = 8'h00;
        ovf_clr = 1'b0;
        rx_en   = 1'b1;
        checks  = 0;
        errors  = 0;
        tick();
        test_reset();
        test_single();
        test_back_to_back();
        test_overflow();
        test_reset_midframe();
`ifdef CORE_OUTPORT_UART_TX_PARITY_EN
        test_parity();
`endif
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire
